// File: rtl/stepper_sysid_regs.sv
// stepper_sysid_regs: Avalon-MM system-ID/status slave with scratch and optional uptime (SYSID_UPTIME_EN)
module stepper_sysid_regs #(
  parameter logic [31:0] ID_VALUE    = 32'h0400_0000,
  parameter logic [31:0] TIMESTAMP   = 32'd1415962224,
  parameter logic [7:0]  VER_MAJOR   = 8'd2,
  parameter logic [7:0]  VER_MINOR   = 8'd0,
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned ADDR_W      = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);
`ifdef SYSID_UPTIME_EN
  localparam logic [15:0] VER_LO = 16'd8;
`else
  localparam logic [15:0] VER_LO = 16'd6;
`endif
  logic [31:0] rdata_q, rdata_d, scratch_q, scratch_d, rmux;
  logic        rvalid_q, rvalid_d, mapped;
  logic [2:0]  wa;
  assign mapped        = (address >> 3) == '0;
  assign wa            = address[2:0];
  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;
`ifdef SYSID_UPTIME_EN
  localparam int unsigned PS_W = CLK_FREQ_HZ > 1 ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_FREQ_HZ - 1);
  logic [PS_W-1:0] ps_q, ps_d, snap_q, snap_d;
  logic [31:0]     sec_q, sec_d;
  logic            wrap, clr, rd_sec;
  // prescaler/seconds advance; a CTRL clear overrides a coincident wrap; reading seconds snapshots the prescaler
  always_comb begin
    wrap   = ps_q == PS_MAX;
    clr    = write && mapped && wa == 3'd6 && writedata[0];
    rd_sec = read && mapped && wa == 3'd4;
    ps_d   = (clr || wrap) ? '0 : ps_q + PS_W'(1);
    sec_d  = clr ? '0 : wrap ? sec_q + 32'd1 : sec_q;
    snap_d = rd_sec ? ps_q : snap_q;
  end
  // uptime state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ps_q   <= '0;
      sec_q  <= '0;
      snap_q <= '0;
    end else begin
      ps_q   <= ps_d;
      sec_q  <= sec_d;
      snap_q <= snap_d;
    end
  end
`endif
  // register map read mux; evaluated from pre-write state so a same-cycle write is not visible
  always_comb begin
    rmux = '0;
    if (mapped)
      case (wa)
        3'd0: rmux = ID_VALUE;
        3'd1: rmux = TIMESTAMP;
        3'd2: rmux = {VER_MAJOR, VER_MINOR, VER_LO};
        3'd3: rmux = scratch_q;
`ifdef SYSID_UPTIME_EN
        3'd4: rmux = sec_q;
        3'd5: rmux = 32'(snap_q);
`endif
        3'd7: rmux = 32'(CLK_FREQ_HZ);
        default: rmux = '0;
      endcase
  end
  // registered read response and byte-lane scratch writes
  always_comb begin
    rvalid_d  = read;
    rdata_d   = read ? rmux : rdata_q;
    scratch_d = scratch_q;
    for (int i = 0; i < 4; i++)
      scratch_d[8*i +: 8] = (write && mapped && wa == 3'd3 && byteenable[i]) ? writedata[8*i +: 8] : scratch_q[8*i +: 8];
  end
  // bus-facing state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      scratch_q <= '0;
    end else begin
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      scratch_q <= scratch_d;
    end
  end
endmodule
